// File: rtl/pp_accum_bank_if.sv
// Handshake bundle for pp_accum_bank: partial-product input stream and per-lane result output.
interface pp_accum_bank_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ACC_DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(ACC_DEPTH);

  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*2*DATA_WIDTH-1:0] inData;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*DATA_WIDTH-1:0]   outData;
  logic [LANES-1:0]              resultIsInvalid;
  logic [CNT_W-1:0]              beat_cnt;

  modport master (
    output in_valid, inData, out_ready,
    input  in_ready, out_valid, outData, resultIsInvalid, beat_cnt
  );

  modport slave (
    input  in_valid, inData, out_ready,
    output in_ready, out_valid, outData, resultIsInvalid, beat_cnt
  );
endinterface

// File: rtl/pp_accum_bank.sv
// Multi-lane partial-product accumulator: sums ACC_DEPTH beats per lane, holds the result.
// Define PPACC_SATURATE_EN to saturate overflowed lanes to all-ones instead of truncating.
module pp_accum_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ACC_DEPTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  pp_accum_bank_if.slave bus
);

  localparam int unsigned PP_W  = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W = PP_W + $clog2(ACC_DEPTH);
  localparam int unsigned CNT_W = $clog2(ACC_DEPTH);

  typedef enum logic {StAccum, StHold} state_e;

  state_e                      r_state;
  state_e                      w_state_next;
  logic [ACC_W-1:0]            r_acc [LANES];
  logic [ACC_W-1:0]            w_sum [LANES];
  logic [CNT_W-1:0]            r_beat_cnt;
  logic [LANES*DATA_WIDTH-1:0] r_out_data;
  logic [LANES-1:0]            r_flags;
  logic [LANES*DATA_WIDTH-1:0] w_res;
  logic [LANES-1:0]            w_ovf;
  logic                        w_in_ready;
  logic                        w_out_valid;
  logic                        w_accept;
  logic                        w_last;

  assign w_accept = bus.in_valid && w_in_ready && !flush;
  assign w_last   = w_accept && (r_beat_cnt == CNT_W'(ACC_DEPTH - 1));

  // Sum includes the current beat so the last beat's result is formed without an extra cycle.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_sum[g] = r_acc[g] + ACC_W'(bus.inData[g*PP_W +: PP_W]);
    assign w_ovf[g] = |w_sum[g][ACC_W-1:DATA_WIDTH];
`ifdef PPACC_SATURATE_EN
    assign w_res[g*DATA_WIDTH +: DATA_WIDTH] =
      w_ovf[g] ? {DATA_WIDTH{1'b1}} : w_sum[g][DATA_WIDTH-1:0];
`else
    assign w_res[g*DATA_WIDTH +: DATA_WIDTH] = w_sum[g][DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StAccum;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = StAccum;
    end else begin
      unique case (r_state)
        StAccum: if (w_last)        w_state_next = StHold;
        StHold:  if (bus.out_ready) w_state_next = StAccum;
        default: w_state_next = StAccum;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      StAccum: w_in_ready  = 1'b1;
      StHold:  w_out_valid = 1'b1;
      default: w_in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
      r_beat_cnt <= '0;
    end else if (flush || w_last) begin
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) r_acc[i] <= w_sum[i];
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data <= '0;
      r_flags    <= '0;
    end else if (flush) begin
      r_out_data <= '0;
      r_flags    <= '0;
    end else if (w_last) begin
      r_out_data <= w_res;
      r_flags    <= w_ovf;
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = w_out_valid;
  assign bus.outData         = r_out_data;
  assign bus.resultIsInvalid = r_flags;
  assign bus.beat_cnt        = r_beat_cnt;

endmodule

// File: tb/tb_pp_accum_bank.sv
// Directed bench for pp_accum_bank with a result scoreboard (DATA_WIDTH=8, LANES=4, ACC_DEPTH=4).
module tb_pp_accum_bank;

  localparam int unsigned DW    = 8;
  localparam int unsigned LN    = 4;
  localparam int unsigned DEP   = 4;
  localparam int unsigned PP_W  = 2 * DW;
  localparam int unsigned ACC_W = PP_W + $clog2(DEP);

  typedef struct packed {
    logic [LN*DW-1:0] data;
    logic [LN-1:0]    flg;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  pp_accum_bank_if #(.DATA_WIDTH(DW), .LANES(LN), .ACC_DEPTH(DEP)) bus ();

  pp_accum_bank #(.DATA_WIDTH(DW), .LANES(LN), .ACC_DEPTH(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [ACC_W-1:0] m_acc [LN];
  int               m_cnt;
  bit               m_hold;
  res_t             exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LN; i++) m_acc[i] = '0;
    m_cnt  = 0;
    m_hold = 1'b0;
  endtask

  function automatic res_t expect_result();
    res_t r;
    for (int i = 0; i < LN; i++) begin
      if (m_acc[i] > ACC_W'((1 << DW) - 1)) begin
        r.flg[i] = 1'b1;
`ifdef PPACC_SATURATE_EN
        r.data[i*DW +: DW] = {DW{1'b1}};
`else
        r.data[i*DW +: DW] = m_acc[i][DW-1:0];
`endif
      end else begin
        r.flg[i]           = 1'b0;
        r.data[i*DW +: DW] = m_acc[i][DW-1:0];
      end
    end
    return r;
  endfunction

  // Entered and left just after a rising edge; drives one cycle of stimulus.
  task automatic step(input logic v, input logic [LN*PP_W-1:0] d, input logic ordy,
                      input logic fl);
    bus.in_valid  = v;
    bus.inData    = d;
    bus.out_ready = ordy;
    flush         = fl;
    chk("in_ready", 64'(bus.in_ready), 64'(!m_hold));
    chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
    if (m_hold && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("out_data", 64'(bus.outData), 64'(exp_q[0].data));
        chk("out_flags", 64'(bus.resultIsInvalid), 64'(exp_q[0].flg));
      end
    end
    @(posedge clk);
    #1;
    if (fl) begin
      if (m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
      model_clear();
    end else if (m_hold) begin
      if (ordy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_hold = 1'b0;
      end
    end else if (v) begin
      for (int i = 0; i < LN; i++) m_acc[i] += ACC_W'(d[i*PP_W +: PP_W]);
      m_cnt++;
      if (m_cnt == DEP) begin
        exp_q.push_back(expect_result());
        model_clear();
        m_hold = 1'b1;
      end
    end
    chk("beat_cnt", 64'(bus.beat_cnt), 64'(m_cnt));
  endtask

  task automatic beats(input int n, input logic [LN*PP_W-1:0] d);
    for (int k = 0; k < n; k++) step(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.inData    = '0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.outData), 64'd0);
    chk("rst_flags", 64'(bus.resultIsInvalid), 64'd0);
    chk("rst_beat_cnt", 64'(bus.beat_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Basic sum, then hold with in_valid still high and out_ready low.
    beats(4, {16'd4, 16'd3, 16'd2, 16'd1});
    chk("basic_data", 64'(bus.outData), 64'h100C0804);
    chk("basic_flags", 64'(bus.resultIsInvalid), 64'h0);
    for (int k = 0; k < 3; k++) step(1'b1, {16'd9, 16'd9, 16'd9, 16'd9}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Lane 0 just overflows.
    beats(4, {48'd0, 16'h0040});
`ifdef PPACC_SATURATE_EN
    chk("ovf0_data", 64'(bus.outData), 64'h000000FF);
`else
    chk("ovf0_data", 64'(bus.outData), 64'h00000000);
`endif
    chk("ovf0_flags", 64'(bus.resultIsInvalid), 64'h1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Exactly the maximum representable value.
    beats(3, {48'd0, 16'h0040});
    beats(1, {48'd0, 16'h003F});
    chk("max_data", 64'(bus.outData), 64'h000000FF);
    chk("max_flags", 64'(bus.resultIsInvalid), 64'h0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Lane 3 at full partial-product scale: wide accumulator must not wrap.
    beats(4, {16'hFFFF, 16'd0, 16'd5, 16'd0});
`ifdef PPACC_SATURATE_EN
    chk("big3_data", 64'(bus.outData), 64'hFF001400);
`else
    chk("big3_data", 64'(bus.outData), 64'hFC001400);
`endif
    chk("big3_flags", 64'(bus.resultIsInvalid), 64'h8);
    step(1'b0, '0, 1'b1, 1'b0);

    // Gapped in_valid.
    for (int k = 0; k < 8; k++) step(k % 2 == 0, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b0, 1'b0);
    chk("gap_data", 64'(bus.outData), 64'h04040404);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush mid-accumulation discards both earlier beats and the coincident one.
    beats(2, {16'd7, 16'd7, 16'd7, 16'd7});
    chk("pre_flush_cnt", 64'(bus.beat_cnt), 64'd2);
    step(1'b1, {16'd7, 16'd7, 16'd7, 16'd7}, 1'b0, 1'b1);
    chk("flush_cnt", 64'(bus.beat_cnt), 64'd0);
    beats(4, {16'd1, 16'd1, 16'd1, 16'd1});
    chk("flush_data", 64'(bus.outData), 64'h04040404);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset while holding a result.
    beats(4, {16'd9, 16'd9, 16'd9, 16'd9});
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_hold_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_hold_data", 64'(bus.outData), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    beats(4, {16'd2, 16'd2, 16'd2, 16'd2});
    chk("post_rst_data", 64'(bus.outData), 64'h08080808);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
